// File: rtl/clk_div_ctrl.sv
// Programmable clock-divide controller: divided clock level plus end-of-period tick,
// with ratio changes and stops deferred to period boundaries. Optional CLK_DIV_CTRL_PCNT_EN adds a tick counter.
module clk_div_ctrl #(
   parameter int DIV_W       = 5,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [DIV_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic [DIV_W-1:0] cur_div,
   output logic             div_clk,
   output logic             tick,
`ifdef CLK_DIV_CTRL_PCNT_EN
   input  logic             period_clr,
   output logic [15:0]      period_cnt,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;

   state_e           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] cur_div_q, cur_div_d;
   logic [DIV_W-1:0] pend_q, pend_d;
   logic             cfg_err_q, cfg_err_d;
   logic             div_clk_q, div_clk_d;
   logic             tick_q, tick_d;
   logic             accept, legal, boundary, run_d;

   assign cfg_ready = (state_q != PEND);
   assign busy      = (state_q != IDLE);
   assign accept    = cfg_valid && cfg_ready;
   assign legal     = (cfg_div >= DIV_W'(2));
   assign boundary  = (state_q != IDLE) && (cnt_q == cur_div_q - DIV_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cur_div_q <= DIV_W'(DEFAULT_DIV);
         pend_q    <= '0;
         cfg_err_q <= 1'b0;
         div_clk_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cur_div_q <= cur_div_d;
         pend_q    <= pend_d;
         cfg_err_q <= cfg_err_d;
         div_clk_q <= div_clk_d;
         tick_q    <= tick_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cur_div_d = cur_div_q;
      pend_d    = pend_q;
      cfg_err_d = accept && !legal;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept && legal) cur_div_d = cfg_div;
            if (en) state_d = RUN;
         end
         RUN: begin
            if (boundary) begin
               // A config accepted on the boundary itself applies right away.
               cnt_d = '0;
               if (accept && legal) cur_div_d = cfg_div;
               state_d = en ? RUN : IDLE;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
               if (accept && legal) begin
                  pend_d  = cfg_div;
                  state_d = PEND;
               end
            end
         end
         PEND: begin
            if (boundary) begin
               cnt_d     = '0;
               cur_div_d = pend_q;
               pend_d    = '0;
               state_d   = en ? RUN : IDLE;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from next-state values so each matches the cnt held alongside it.
   always_comb begin
      run_d     = (state_d != IDLE);
      div_clk_d = run_d && (cnt_d >= (cur_div_d - (cur_div_d >> 1)));
      tick_d    = run_d && (cnt_d == cur_div_d - DIV_W'(1));
   end

   assign cfg_err = cfg_err_q;
   assign cur_div = cur_div_q;
   assign div_clk = div_clk_q;
   assign tick    = tick_q;

`ifdef CLK_DIV_CTRL_PCNT_EN
   logic [15:0] pcnt_q;

   always_ff @(posedge clk) begin
      if (rst || period_clr) pcnt_q <= '0;
      else if (tick_q)       pcnt_q <= pcnt_q + 16'd1;
   end

   assign period_cnt = pcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: per-cycle vector table through a scoreboard queue,
// plus a maximum-ratio run with a graceful stop.
module tb_clk_div_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [4:0] cfg_div = 5'd0;
   logic       cfg_ready, cfg_err, div_clk, tick, busy;
   logic [4:0] cur_div;
`ifdef CLK_DIV_CTRL_PCNT_EN
   logic        period_clr = 1'b0;
   logic [15:0] period_cnt;
`endif

   always #5 clk = ~clk;

   clk_div_ctrl #(.DIV_W(5), .DEFAULT_DIV(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .cur_div   (cur_div),
      .div_clk   (div_clk),
      .tick      (tick),
`ifdef CLK_DIV_CTRL_PCNT_EN
      .period_clr(period_clr),
      .period_cnt(period_cnt),
`endif
      .busy      (busy)
   );

   // Expected bundle: {cfg_ready, cfg_err, cur_div[4:0], div_clk, tick, busy}
   typedef struct {
      logic       r;
      logic       e;
      logic       v;
      logic [4:0] d;
      logic [9:0] x;
   } vec_t;

   vec_t       tv[$];
   logic [9:0] sb[$];
   int         total = 0;
   int         bad = 0;
   int         tk = 0;

   task automatic add(input logic r, e, v, input logic [4:0] d,
                      input logic rdy, er, input logic [4:0] cu, input logic dc, tc, bz);
      vec_t t;
      t.r = r; t.e = e; t.v = v; t.d = d;
      t.x = {rdy, er, cu, dc, tc, bz};
      tv.push_back(t);
   endtask

   task automatic apply(input logic r, e, v, input logic [4:0] d, input logic [9:0] x, input string nm);
      logic [9:0] act, exp;
      @(negedge clk);
      rst = r; en = e; cfg_valid = v; cfg_div = d;
      sb.push_back(x);
      @(posedge clk);
      #1;
      act = {cfg_ready, cfg_err, cur_div, div_clk, tick, busy};
      exp = sb.pop_front();
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got rdy=%b err=%b cur=%0d dclk=%b tick=%b busy=%b, want rdy=%b err=%b cur=%0d dclk=%b tick=%b busy=%b",
                  nm, act[9], act[8], act[7:3], act[2], act[1], act[0],
                  exp[9], exp[8], exp[7:3], exp[2], exp[1], exp[0]);
      end
      if (r) tk = 0;
      else if (tick) tk++;
   endtask

   initial begin
      // rst en v div | rdy err cur dclk tick busy
      add(1,0,0,0,  1,0,2,0,0,0);  // reset
      add(0,1,0,0,  1,0,2,0,0,1);  // N=2 start, cnt0
      add(0,1,0,0,  1,0,2,1,1,1);
      add(0,1,0,0,  1,0,2,0,0,1);
      add(0,1,0,0,  1,0,2,1,1,1);
      add(0,0,0,0,  1,0,2,0,0,0);  // stop at boundary
      add(0,0,1,5,  1,0,5,0,0,0);  // config in IDLE
      add(0,1,0,0,  1,0,5,0,0,1);  // N=5: 3 low, 2 high
      add(0,1,0,0,  1,0,5,0,0,1);
      add(0,1,0,0,  1,0,5,0,0,1);
      add(0,1,0,0,  1,0,5,1,0,1);
      add(0,1,0,0,  1,0,5,1,1,1);
      add(0,1,0,0,  1,0,5,0,0,1);
      add(0,1,1,4,  0,0,5,0,0,1);  // accept mid-period -> PEND
      add(0,1,1,7,  0,0,5,0,0,1);  // not ready, ignored
      add(0,1,0,0,  0,0,5,1,0,1);
      add(0,1,0,0,  0,0,5,1,1,1);
      add(0,1,0,0,  1,0,4,0,0,1);  // N=4 applied
      add(0,1,0,0,  1,0,4,0,0,1);
      add(0,1,1,3,  0,0,4,1,0,1);  // write 3 at cnt=1
      add(0,1,0,0,  0,0,4,1,1,1);
      add(0,1,0,0,  1,0,3,0,0,1);  // N=3: 2 low, 1 high
      add(0,1,0,0,  1,0,3,0,0,1);
      add(0,1,0,0,  1,0,3,1,1,1);
      add(0,1,0,0,  1,0,3,0,0,1);
      add(0,1,1,1,  1,1,3,0,0,1);  // illegal 1
      add(0,1,0,0,  1,0,3,1,1,1);
      add(0,1,1,0,  1,1,3,0,0,1);  // illegal 0 on boundary
      add(0,1,0,0,  1,0,3,0,0,1);
      add(0,1,0,0,  1,0,3,1,1,1);
      add(0,1,1,6,  1,0,6,0,0,1);  // accept on boundary: no PEND
      add(0,0,0,0,  1,0,6,0,0,1);  // en low from cnt0
      add(0,0,0,0,  1,0,6,0,0,1);
      add(0,0,0,0,  1,0,6,1,0,1);
      add(0,0,0,0,  1,0,6,1,0,1);
      add(0,0,0,0,  1,0,6,1,1,1);
      add(0,0,0,0,  1,0,6,0,0,0);  // full period then IDLE
      add(0,1,0,0,  1,0,6,0,0,1);
      add(0,1,0,0,  1,0,6,0,0,1);
      add(0,0,0,0,  1,0,6,0,0,1);  // en glitch mid-period
      add(0,0,0,0,  1,0,6,1,0,1);
      add(0,1,0,0,  1,0,6,1,0,1);
      add(0,1,0,0,  1,0,6,1,1,1);
      add(0,1,0,0,  1,0,6,0,0,1);  // no stop
      add(0,1,1,9,  0,0,6,0,0,1);  // PEND with 9
      add(1,1,0,0,  1,0,2,0,0,0);  // reset in PEND
      add(0,1,0,0,  1,0,2,0,0,1);
      add(0,1,0,0,  1,0,2,1,1,1);
      add(0,1,0,0,  1,0,2,0,0,1);
      add(0,1,0,0,  1,0,2,1,1,1);  // pending 9 dropped
      add(0,0,0,0,  1,0,2,0,0,0);
      add(0,1,1,3,  1,0,3,0,0,1);  // en rise + config together
      add(0,1,0,0,  1,0,3,0,0,1);
      add(0,1,0,0,  1,0,3,1,1,1);
      add(0,1,0,0,  1,0,3,0,0,1);

      for (int i = 0; i < tv.size(); i++)
         apply(tv[i].r, tv[i].e, tv[i].v, tv[i].d, tv[i].x, $sformatf("vec%0d", i));

      // Maximum ratio 31: high for cnt>=16, tick at cnt=30, graceful stop after en drops.
      apply(1, 0, 0, 5'd0, {1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0}, "max_rst");
      apply(0, 1, 1, 5'd31, {1'b1, 1'b0, 5'd31, 1'b0, 1'b0, 1'b1}, "max_start");
      for (int k = 1; k <= 93; k++) begin
         int  c;
         logic dc, tc, bz;
         c  = k % 31;
         bz = (k < 93);
         dc = bz && (c >= 16);
         tc = bz && (c == 30);
         apply(1'b0, (k <= 62), 1'b0, 5'd0, {1'b1, 1'b0, 5'd31, dc, tc, bz}, $sformatf("max_k%0d", k));
      end

`ifdef CLK_DIV_CTRL_PCNT_EN
      total++;
      if (period_cnt !== 16'(tk)) begin
         bad++;
         $display("FAIL period_cnt: got %0d, want %0d", period_cnt, tk);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
